// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and its ALU.
package muldiv_pkg;

  localparam logic [1:0] MD_MUL   = 2'd0;
  localparam logic [1:0] MD_MULHU = 2'd1;
  localparam logic [1:0] MD_DIVU  = 2'd2;
  localparam logic [1:0] MD_REMU  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // ALU select codes, also used by the decode stage.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared with the execute stage.
module alu
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] f,
  output logic             zflag
);

  always_comb begin
    f = '0;
    case (sel)
      ALU_ADD: f = a + b;
      ALU_SUB: f = a - b;
      ALU_AND: f = a & b;
      ALU_OR:  f = a | b;
      ALU_XOR: f = a ^ b;
      default: f = '0;
    endcase
  end

  assign zflag = (f == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU: shift-add multiply and restoring divide,
// one pass through a shared (WIDTH+1)-bit ALU per cycle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  state_e           r_state;
  logic [1:0]       r_op;
  logic [CNTW-1:0]  r_cnt;
  // r_hi is acc_hi / rem, r_lo is acc_lo / quo, r_b is mcand / dvsr.
  logic [WIDTH-1:0] r_hi, r_lo, r_b, r_result;
  logic             r_busy, r_done, r_dbz;

  logic             w_is_div, w_start_dbz, w_fin_dbz, w_unused_zflag;
  logic [WIDTH:0]   w_shift, w_alu_a, w_alu_b, w_alu_f;
  logic [3:0]       w_alu_sel;
  logic [WIDTH-1:0] w_fin_result;

  assign w_is_div    = (r_op == MD_DIVU) || (r_op == MD_REMU);
  assign w_start_dbz = ((op == MD_DIVU) || (op == MD_REMU)) && (b == '0);
  assign w_fin_dbz   = w_is_div && (r_b == '0);
  assign w_shift     = {r_hi, r_lo[WIDTH-1]};

  always_comb begin
    w_alu_sel = ALU_ADD;
    w_alu_a   = {1'b0, r_hi};
    w_alu_b   = {1'b0, r_b};
    if (r_state == S_RUN && w_is_div) begin
      w_alu_sel = ALU_SUB;
      w_alu_a   = w_shift;
    end
  end

  alu #(
    .WIDTH(WIDTH + 1)
  ) u_alu (
    .a    (w_alu_a),
    .b    (w_alu_b),
    .sel  (w_alu_sel),
    .f    (w_alu_f),
    .zflag(w_unused_zflag)
  );

  // A zero-divisor op skips RUN, so r_lo still holds the dividend here.
  always_comb begin
    w_fin_result = r_lo;
    unique case (r_op)
      MD_MUL:   w_fin_result = r_lo;
      MD_MULHU: w_fin_result = r_hi;
      MD_DIVU:  w_fin_result = w_fin_dbz ? '1 : r_lo;
      MD_REMU:  w_fin_result = w_fin_dbz ? r_lo : r_hi;
      default:  w_fin_result = r_lo;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= MD_MUL;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_hi    <= '0;
            r_lo    <= a;
            r_b     <= b;
            r_cnt   <= CNTW'(WIDTH);
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_state <= w_start_dbz ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_is_div) begin
            r_hi <= w_alu_f[WIDTH] ? w_shift[WIDTH-1:0] : w_alu_f[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], ~w_alu_f[WIDTH]};
          end else if (r_lo[0]) begin
            r_hi <= w_alu_f[WIDTH:1];
            r_lo <= {w_alu_f[0], r_lo[WIDTH-1:1]};
          end else begin
            r_hi <= {1'b0, r_hi[WIDTH-1:1]};
            r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
          end
          if (r_cnt == CNTW'(1)) r_state <= S_FIN;
        end
        S_FIN: begin
          r_result <= w_fin_result;
          r_dbz    <= w_fin_dbz;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule
